nes_mem_arbiter: RTL and testbench
==================================

// Module: nes_mem_arbiter
// PURPOSE
//  Shares one single-port NES memory/cartridge bus between three requesters: PPU, OAM-DMA and CPU.
//  Sits between the CPU/PPU/DMA cores and the memory controller inside the nes top level.
//  Fixed priority: PPU > DMA > CPU. One transaction is outstanding at a time; it is never pre-empted.
// PARAMETERS
//  ADDR_WIDTH      16   requester and memory address width
//  DATA_WIDTH      8    data width
//  TIMEOUT_CYCLES  255  max mem_req-high cycles without mem_ack (NES_ARB_TIMEOUT_EN only); must be >= 1
// PORTS
//  clk          in   1           system clock
//  rst          in   1           asynchronous reset, active-high
//  i_ppu_req    in   1           PPU request; hold high with addr/we/wdata stable until o_ppu_ack
//  i_ppu_addr   in   ADDR_WIDTH  PPU address
//  i_ppu_we     in   1           PPU write (1) / read (0)
//  i_ppu_wdata  in   DATA_WIDTH  PPU write data
//  o_ppu_ack    out  1           one-cycle completion pulse to PPU
//  i_dma_*      in   as PPU      DMA req/addr/we/wdata, same rules
//  o_dma_ack    out  1           one-cycle completion pulse to DMA
//  i_cpu_*      in   as PPU      CPU req/addr/we/wdata, same rules
//  o_cpu_ack    out  1           one-cycle completion pulse to CPU
//  o_rdata      out  DATA_WIDTH  read data; valid in the ack cycle, held until next capture
//  o_grant      out  3           one-hot owner {cpu,dma,ppu}; 0 when idle
//  o_busy       out  1           transaction in progress (state != IDLE)
//  o_mem_req    out  1           memory request, held until o_mem_ack sampled
//  o_mem_addr   out  ADDR_WIDTH  latched address
//  o_mem_we     out  1           latched write enable
//  o_mem_wdata  out  DATA_WIDTH  latched write data
//  i_mem_ack    in   1           memory completion; i_mem_rdata valid in the same cycle
//  i_mem_rdata  in   DATA_WIDTH  memory read data
//  i_err_clr    in   1           clears o_timeout_err
//  o_timeout_err out 1           sticky timeout flag
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; latched addr/we/wdata 0. Reset mid-transaction drops o_mem_req
//   immediately and abandons the transaction without an ack; requesters re-request after reset.
//  FSM, all outputs registered:
//   IDLE: any req sampled at edge T -> grant highest-priority requester, latch its addr/we/wdata,
//    o_mem_req=1, o_grant set, ISSUE. Reqs arriving in the same cycle resolve by priority.
//   ISSUE: o_mem_req held high with stable addr/we/wdata. i_mem_ack sampled at edge E ->
//    o_mem_req=0, o_rdata<=i_mem_rdata (reads only; writes leave o_rdata unchanged),
//    granted ack=1 for one cycle, DONE.
//   DONE: ack returns to 0, o_grant=0, IDLE. Requester drops or changes req at the edge after ack;
//    DONE guarantees the stale req is never re-sampled.
//  Latency: i_mem_ack one cycle after T gives ack visible after T+1. Minimum 3 cycles per transaction.
//  Requests not granted stay pending; the arbiter never drops a waiting req.
//  A requester deasserting req before ack is a protocol violation; the transaction completes anyway.
//  i_mem_ack outside ISSUE is ignored.
//  Starvation of CPU/DMA by continuous PPU traffic is accepted by design.
// CONFIGURATION
//  NES_ARB_TIMEOUT_EN defined:
//   An 8..32-bit counter increments each ISSUE cycle without i_mem_ack.
//   After TIMEOUT_CYCLES such cycles: o_mem_req=0, o_rdata=all ones, granted ack pulses,
//    o_timeout_err=1 (sticky), DONE.
//   i_err_clr clears the flag; a new timeout in the same cycle wins.
//  NES_ARB_TIMEOUT_EN undefined: ISSUE waits indefinitely; o_timeout_err tied 0; i_err_clr ignored.
// TESTING
//  1 CPU read 0x8000, mem acks next cycle with 0xA5 -> o_mem_req 1 cycle; o_cpu_ack 1 cycle;
//    o_rdata=0xA5; o_busy low 3 cycles after req.
//  2 PPU, DMA, CPU req same cycle -> service order PPU, DMA, CPU; each ack exactly once;
//    o_grant 001, 010, 100.
//  3 DMA write 0x2004<=0x3C with mem_ack delayed 10 cycles -> addr/we/wdata stable for all 10 cycles;
//    o_rdata unchanged.
//  4 CPU held ack-ready, PPU req arrives in CPU ISSUE -> CPU completes first; PPU granted next IDLE.
//  5 rst asserted mid-ISSUE -> o_mem_req, acks, o_grant, o_busy 0 same cycle; no ack after release.
//  6 (NES_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4) CPU read, mem never acks -> ack after 4 cycles;
//    o_rdata=0xFF; o_timeout_err=1 until i_err_clr pulse.

Source files
------------

// File: rtl/nes_mem_arbiter.sv
// Fixed-priority (PPU > DMA > CPU) arbiter for the single-port NES memory bus.
// Optional ISSUE watchdog is built in when NES_ARB_TIMEOUT_EN is defined.
module nes_mem_arbiter #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_ppu_req,
  input  logic [ADDR_WIDTH-1:0] i_ppu_addr,
  input  logic                  i_ppu_we,
  input  logic [DATA_WIDTH-1:0] i_ppu_wdata,
  output logic                  o_ppu_ack,
  input  logic                  i_dma_req,
  input  logic [ADDR_WIDTH-1:0] i_dma_addr,
  input  logic                  i_dma_we,
  input  logic [DATA_WIDTH-1:0] i_dma_wdata,
  output logic                  o_dma_ack,
  input  logic                  i_cpu_req,
  input  logic [ADDR_WIDTH-1:0] i_cpu_addr,
  input  logic                  i_cpu_we,
  input  logic [DATA_WIDTH-1:0] i_cpu_wdata,
  output logic                  o_cpu_ack,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic [2:0]            o_grant,
  output logic                  o_busy,
  output logic                  o_mem_req,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_we,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic                  i_mem_ack,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  input  logic                  i_err_clr,
  output logic                  o_timeout_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t                state_reg;
  logic [2:0]            req_vec;
  logic [2:0]            we_vec;
  logic [2:0]            pick;
  logic [2:0]            ack_reg;
  logic [ADDR_WIDTH-1:0] addr_arr  [3];
  logic [DATA_WIDTH-1:0] wdata_arr [3];
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic                  sel_we;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  timeout_hit;

  // Index 0 = PPU, 1 = DMA, 2 = CPU; lower index wins.
  assign req_vec      = {i_cpu_req, i_dma_req, i_ppu_req};
  assign we_vec       = {i_cpu_we, i_dma_we, i_ppu_we};
  assign addr_arr[0]  = i_ppu_addr;
  assign addr_arr[1]  = i_dma_addr;
  assign addr_arr[2]  = i_cpu_addr;
  assign wdata_arr[0] = i_ppu_wdata;
  assign wdata_arr[1] = i_dma_wdata;
  assign wdata_arr[2] = i_cpu_wdata;

  // Isolating the lowest set request bit yields the one-hot winner.
  assign pick = req_vec & (~req_vec + 3'd1);

  always_comb begin
    sel_addr  = '0;
    sel_we    = 1'b0;
    sel_wdata = '0;
    for (int i = 0; i < 3; i++) begin
      if (pick[i]) begin
        sel_addr  = addr_arr[i];
        sel_we    = we_vec[i];
        sel_wdata = wdata_arr[i];
      end
    end
  end

  assign o_ppu_ack = ack_reg[0];
  assign o_dma_ack = ack_reg[1];
  assign o_cpu_ack = ack_reg[2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      o_grant     <= '0;
      o_busy      <= 1'b0;
      o_mem_req   <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_we    <= 1'b0;
      o_mem_wdata <= '0;
      o_rdata     <= '0;
      ack_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (|req_vec) begin
            state_reg   <= ISSUE;
            o_grant     <= pick;
            o_busy      <= 1'b1;
            o_mem_req   <= 1'b1;
            o_mem_addr  <= sel_addr;
            o_mem_we    <= sel_we;
            o_mem_wdata <= sel_wdata;
          end
        end
        ISSUE: begin
          if (i_mem_ack) begin
            o_mem_req <= 1'b0;
            if (!o_mem_we) o_rdata <= i_mem_rdata;
            ack_reg   <= o_grant;
            state_reg <= DONE;
          end else if (timeout_hit) begin
            o_mem_req <= 1'b0;
            o_rdata   <= '1;
            ack_reg   <= o_grant;
            state_reg <= DONE;
          end
        end
        DONE: begin
          // One-cycle gap so a requester's stale req is never re-sampled.
          ack_reg   <= '0;
          o_grant   <= '0;
          o_busy    <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef NES_ARB_TIMEOUT_EN
  localparam int CLOG = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW   = (CLOG < 8) ? 8 : ((CLOG > 32) ? 32 : CLOG);

  logic [CW-1:0] cnt_reg;
  logic          err_reg;

  assign timeout_hit   = (state_reg == ISSUE) && !i_mem_ack &&
                         (cnt_reg == CW'(TIMEOUT_CYCLES - 1));
  assign o_timeout_err = err_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
      err_reg <= 1'b0;
    end else begin
      if (state_reg == ISSUE && !i_mem_ack && !timeout_hit) cnt_reg <= cnt_reg + 1'b1;
      else                                                  cnt_reg <= '0;
      // A fresh timeout takes precedence over a simultaneous clear.
      if (timeout_hit)    err_reg <= 1'b1;
      else if (i_err_clr) err_reg <= 1'b0;
    end
  end
`else
  logic unused_err_clr;

  assign unused_err_clr = i_err_clr;
  assign timeout_hit    = 1'b0;
  assign o_timeout_err  = 1'b0;
`endif

endmodule

// File: tb/tb_nes_mem_arbiter.sv
// Self-checking bench for nes_mem_arbiter: directed scenarios plus a randomized
// three-requester run checked against a transaction-level memory/priority model.
module tb_nes_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_d;
  logic [2:0]  we_d;
  logic [15:0] addr_d  [3];
  logic [7:0]  wdata_d [3];
  logic [2:0]  ack_w;
  logic [7:0]  o_rdata;
  logic [2:0]  o_grant;
  logic        o_busy, o_mem_req, o_mem_we, o_timeout_err;
  logic [15:0] o_mem_addr;
  logic [7:0]  o_mem_wdata;
  logic        i_mem_ack;
  logic [7:0]  i_mem_rdata;
  logic        err_clr;

  int checks = 0;
  int errors = 0;

  // Bench memory (responder side) and reference model memory.
  logic [7:0] mem     [65536];
  logic [7:0] ref_mem [65536];

  bit mem_auto  = 1'b0;
  bit mem_rand  = 1'b0;
  bit mem_force = 1'b0;
  int mem_delay = 0;
  int wait_cnt  = 0;

`ifdef NES_ARB_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  nes_mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .i_ppu_req(req_d[0]), .i_ppu_addr(addr_d[0]), .i_ppu_we(we_d[0]), .i_ppu_wdata(wdata_d[0]),
    .o_ppu_ack(ack_w[0]),
    .i_dma_req(req_d[1]), .i_dma_addr(addr_d[1]), .i_dma_we(we_d[1]), .i_dma_wdata(wdata_d[1]),
    .o_dma_ack(ack_w[1]),
    .i_cpu_req(req_d[2]), .i_cpu_addr(addr_d[2]), .i_cpu_we(we_d[2]), .i_cpu_wdata(wdata_d[2]),
    .o_cpu_ack(ack_w[2]),
    .o_rdata(o_rdata), .o_grant(o_grant), .o_busy(o_busy),
    .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr), .o_mem_we(o_mem_we), .o_mem_wdata(o_mem_wdata),
    .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
    .i_err_clr(err_clr), .o_timeout_err(o_timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory responder: acks mem_delay cycles after first seeing o_mem_req.
  initial begin
    i_mem_ack   = 1'b0;
    i_mem_rdata = 8'h00;
    forever begin
      tick();
      i_mem_ack = 1'b0;
      if (!mem_auto) begin
        i_mem_ack = mem_force;
        wait_cnt  = 0;
      end else if (o_mem_req) begin
        if (wait_cnt >= mem_delay) begin
          i_mem_ack   = 1'b1;
          i_mem_rdata = o_mem_we ? 8'($urandom) : mem[o_mem_addr];
          if (o_mem_we) mem[o_mem_addr] = o_mem_wdata;
          wait_cnt = 0;
          if (mem_rand) mem_delay = $urandom_range(0, 3);
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if ({ack_w, o_rdata, o_grant, o_busy, o_mem_req, o_mem_addr, o_mem_we, o_mem_wdata, o_timeout_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got ack=%b rdata=%h grant=%b busy=%b req=%b addr=%h we=%b wdata=%h err=%b, exp all 0",
               ack_w, o_rdata, o_grant, o_busy, o_mem_req, o_mem_addr, o_mem_we, o_mem_wdata, o_timeout_err);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({o_busy, o_mem_req, o_grant} !== 5'b0) begin
      errors++;
      $display("FAIL reset_release_idle: got busy=%b req=%b grant=%b, exp 0", o_busy, o_mem_req, o_grant);
    end
    $display("test_reset done");
  endtask

  task automatic test_cpu_read();
    mem[16'h8000] = 8'hA5;
    ref_mem[16'h8000] = 8'hA5;
    mem_auto = 1'b1; mem_rand = 1'b0; mem_delay = 0;
    req_d[2] = 1'b1; addr_d[2] = 16'h8000; we_d[2] = 1'b0; wdata_d[2] = 8'h00;
    tick();
    checks++;
    if ({o_mem_req, o_grant, o_busy, ack_w, o_mem_addr, o_mem_we} !== {1'b1, 3'b100, 1'b1, 3'b000, 16'h8000, 1'b0}) begin
      errors++;
      $display("FAIL cpu_read_issue: got req=%b grant=%b busy=%b ack=%b addr=%h we=%b, exp 1 100 1 000 8000 0",
               o_mem_req, o_grant, o_busy, ack_w, o_mem_addr, o_mem_we);
    end
    tick();
    checks++;
    if ({o_mem_req, ack_w, o_busy, o_rdata} !== {1'b0, 3'b100, 1'b1, 8'hA5}) begin
      errors++;
      $display("FAIL cpu_read_ack: got req=%b ack=%b busy=%b rdata=%h, exp 0 100 1 a5", o_mem_req, ack_w, o_busy, o_rdata);
    end
    req_d[2] = 1'b0;
    tick();
    checks++;
    if ({ack_w, o_grant, o_busy, o_rdata} !== {3'b000, 3'b000, 1'b0, 8'hA5}) begin
      errors++;
      $display("FAIL cpu_read_done: got ack=%b grant=%b busy=%b rdata=%h, exp 000 000 0 a5", ack_w, o_grant, o_busy, o_rdata);
    end
    $display("test_cpu_read done");
  endtask

  task automatic test_dma_write();
    int  req_cycles = 0;
    bit  stable = 1'b1;
    bit  acked  = 1'b0;
`ifdef NES_ARB_TIMEOUT_EN
    mem_delay = 2;
`else
    mem_delay = 10;
`endif
    mem_rand = 1'b0;
    req_d[1] = 1'b1; addr_d[1] = 16'h2004; we_d[1] = 1'b1; wdata_d[1] = 8'h3C;
    for (int c = 0; c < 40 && !acked; c++) begin
      tick();
      if (o_mem_req) begin
        req_cycles++;
        if (o_mem_addr !== 16'h2004 || o_mem_we !== 1'b1 || o_mem_wdata !== 8'h3C) stable = 1'b0;
      end
      if (ack_w[1]) begin
        acked = 1'b1;
        req_d[1] = 1'b0;
      end
    end
    ref_mem[16'h2004] = 8'h3C;
    checks++;
    if (!acked || req_cycles != mem_delay + 1) begin
      errors++;
      $display("FAIL dma_write_latency: got acked=%b req_cycles=%0d, exp 1 %0d", acked, req_cycles, mem_delay + 1);
    end
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL dma_write_stable: got unstable addr/we/wdata, exp 2004/1/3c every cycle");
    end
    checks++;
    if (o_rdata !== 8'hA5) begin
      errors++;
      $display("FAIL dma_write_rdata_held: got %h exp a5", o_rdata);
    end
    tick();
    $display("test_dma_write done");
  endtask

  task automatic test_priority();
    logic [2:0] gseq [$];
    logic [2:0] pg = 3'b000;
    int ack_cnt [3] = '{0, 0, 0};
    bit rd_ok = 1'b1;
    mem_delay = 0;
    for (int i = 0; i < 3; i++) begin
      req_d[i] = 1'b1; addr_d[i] = 16'(16'h0100 + i); we_d[i] = 1'b0; wdata_d[i] = 8'h00;
    end
    for (int c = 0; c < 20; c++) begin
      tick();
      if (o_grant !== 3'b000 && o_grant !== pg) gseq.push_back(o_grant);
      pg = o_grant;
      for (int i = 0; i < 3; i++) begin
        if (ack_w[i]) begin
          ack_cnt[i]++;
          req_d[i] = 1'b0;
          if (o_rdata !== ref_mem[16'(16'h0100 + i)]) rd_ok = 1'b0;
        end
      end
    end
    checks++;
    if (gseq.size() != 3 || gseq[0] !== 3'b001 || gseq[1] !== 3'b010 || gseq[2] !== 3'b100) begin
      errors++;
      $display("FAIL priority_order: got %0d grants first=%b, exp 001,010,100", gseq.size(),
               (gseq.size() > 0) ? gseq[0] : 3'b000);
    end
    checks++;
    if (ack_cnt[0] != 1 || ack_cnt[1] != 1 || ack_cnt[2] != 1) begin
      errors++;
      $display("FAIL priority_acks: got ppu=%0d dma=%0d cpu=%0d, exp 1 each", ack_cnt[0], ack_cnt[1], ack_cnt[2]);
    end
    checks++;
    if (!rd_ok) begin
      errors++;
      $display("FAIL priority_rdata: got wrong read data on at least one ack, exp model memory");
    end
    $display("test_priority done");
  endtask

  task automatic test_no_preempt();
    int ack_order [$];
    logic [2:0] gseq [$];
    logic [2:0] pg;
    bit granted = 1'b0;
    mem_delay = 3;
    req_d[2] = 1'b1; addr_d[2] = 16'h8000; we_d[2] = 1'b0;
    for (int c = 0; c < 10 && !granted; c++) begin
      tick();
      if (o_grant === 3'b100) granted = 1'b1;
    end
    req_d[0] = 1'b1; addr_d[0] = 16'h3F00; we_d[0] = 1'b0;
    gseq.push_back(o_grant);
    pg = o_grant;
    for (int c = 0; c < 25; c++) begin
      tick();
      if (o_grant !== 3'b000 && o_grant !== pg) gseq.push_back(o_grant);
      pg = o_grant;
      for (int i = 0; i < 3; i++) begin
        if (ack_w[i]) begin
          ack_order.push_back(i);
          req_d[i] = 1'b0;
        end
      end
    end
    checks++;
    if (!granted || gseq.size() != 2 || gseq[0] !== 3'b100 || gseq[1] !== 3'b001) begin
      errors++;
      $display("FAIL no_preempt_grants: got granted=%b count=%0d, exp cpu(100) then ppu(001)", granted, gseq.size());
    end
    checks++;
    if (ack_order.size() != 2 || ack_order[0] != 2 || ack_order[1] != 0) begin
      errors++;
      $display("FAIL no_preempt_acks: got %0d acks first=%0d, exp cpu then ppu", ack_order.size(),
               (ack_order.size() > 0) ? ack_order[0] : -1);
    end
    $display("test_no_preempt done");
  endtask

  task automatic test_reset_mid();
    bit quiet = 1'b1;
    mem_auto = 1'b0; mem_force = 1'b0;
    req_d[2] = 1'b1; addr_d[2] = 16'h4016; we_d[2] = 1'b0;
    tick();
    tick();
    checks++;
    if ({o_mem_req, o_busy} !== 2'b11) begin
      errors++;
      $display("FAIL reset_mid_pre: got req=%b busy=%b, exp 1 1", o_mem_req, o_busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({o_mem_req, ack_w, o_grant, o_busy} !== 8'b0) begin
      errors++;
      $display("FAIL reset_mid_async: got req=%b ack=%b grant=%b busy=%b, exp 0", o_mem_req, ack_w, o_grant, o_busy);
    end
    tick();
    rst = 1'b0;
    req_d[2] = 1'b0;
    mem_force = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (ack_w !== 3'b000 || o_busy !== 1'b0 || o_mem_req !== 1'b0) quiet = 1'b0;
    end
    mem_force = 1'b0;
    tick();
    checks++;
    if (!quiet) begin
      errors++;
      $display("FAIL reset_mid_after: got activity after reset release with stray mem_ack, exp none");
    end
    $display("test_reset_mid done");
  endtask

  task automatic test_timeout();
`ifdef NES_ARB_TIMEOUT_EN
    int n = 0;
    bit got = 1'b0;
    bit held = 1'b1;
    mem_auto = 1'b0; mem_force = 1'b0;
    req_d[2] = 1'b1; addr_d[2] = 16'h1234; we_d[2] = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      tick();
      if (ack_w[2]) got = 1'b1;
      else if (o_mem_req) n++;
    end
    req_d[2] = 1'b0;
    checks++;
    if (!got || n != 4) begin
      errors++;
      $display("FAIL timeout_latency: got acked=%b req_cycles=%0d, exp 1 4", got, n);
    end
    checks++;
    if (o_rdata !== 8'hFF || o_timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_result: got rdata=%h err=%b, exp ff 1", o_rdata, o_timeout_err);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      if (o_timeout_err !== 1'b1) held = 1'b0;
    end
    checks++;
    if (!held) begin
      errors++;
      $display("FAIL timeout_sticky: got err dropped without clear, exp held 1");
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++;
    if (o_timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear: got %b exp 0", o_timeout_err);
    end
`else
    err_clr = 1'b1;
    tick();
    tick();
    err_clr = 1'b0;
    checks++;
    if (o_timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_tied: got %b exp 0", o_timeout_err);
    end
`endif
    $display("test_timeout done");
  endtask

  task automatic test_random();
    int         remaining [3];
    bit         active    [3];
    bit         just_done [3];
    int         done_cnt = 0;
    logic [2:0] prev_req = 3'b000;
    logic [2:0] pg = 3'b000;
    logic [2:0] exp_g;
    int         idx;
    logic [7:0] last_rd = 8'h00;
    bit         have_rd = 1'b0;
    mem_auto = 1'b1; mem_rand = 1'b1; mem_delay = 1;
    for (int i = 0; i < 3; i++) begin
      remaining[i] = 30; active[i] = 1'b0; req_d[i] = 1'b0;
    end
    for (int c = 0; c < 6000 && done_cnt < 90; c++) begin
      tick();
      if (o_grant !== 3'b000 && pg === 3'b000) begin
        exp_g = 3'b000; idx = 0;
        for (int i = 2; i >= 0; i--) if (prev_req[i]) begin exp_g = 3'b001 << i; idx = i; end
        checks++;
        if (o_grant !== exp_g || o_mem_addr !== addr_d[idx] || o_mem_we !== we_d[idx]) begin
          errors++;
          $display("FAIL rand_grant: got grant=%b addr=%h we=%b, exp grant=%b addr=%h we=%b (reqs %b)",
                   o_grant, o_mem_addr, o_mem_we, exp_g, addr_d[idx], we_d[idx], prev_req);
        end
      end
      checks++;
      if (o_busy !== (o_grant !== 3'b000)) begin
        errors++;
        $display("FAIL rand_busy: got busy=%b grant=%b, exp busy set exactly while owned", o_busy, o_grant);
      end
      for (int i = 0; i < 3; i++) begin
        just_done[i] = 1'b0;
        if (ack_w[i]) begin
          checks++;
          if (!active[i] || o_grant[i] !== 1'b1) begin
            errors++;
            $display("FAIL rand_ack_spurious: got ack on requester %0d (active=%b grant=%b), exp none", i, active[i], o_grant);
          end else if (!we_d[i] && o_rdata !== ref_mem[addr_d[i]]) begin
            errors++;
            $display("FAIL rand_rdata: got %h exp %h at addr %h", o_rdata, ref_mem[addr_d[i]], addr_d[i]);
          end else if (we_d[i] && have_rd && o_rdata !== last_rd) begin
            errors++;
            $display("FAIL rand_rdata_held: got %h exp %h after write", o_rdata, last_rd);
          end
          if (active[i]) begin
            if (we_d[i]) ref_mem[addr_d[i]] = wdata_d[i];
            else begin last_rd = ref_mem[addr_d[i]]; have_rd = 1'b1; end
            active[i] = 1'b0; just_done[i] = 1'b1; req_d[i] = 1'b0; done_cnt++;
          end
        end
      end
      pg = o_grant;
      for (int i = 0; i < 3; i++) begin
        if (!active[i] && !just_done[i] && remaining[i] > 0 && $urandom_range(0, 2) == 0) begin
          active[i] = 1'b1; remaining[i]--;
          req_d[i] = 1'b1;
          addr_d[i] = 16'($urandom_range(0, 15));
          we_d[i] = 1'($urandom_range(0, 1));
          wdata_d[i] = 8'($urandom);
        end
      end
      prev_req = req_d;
    end
    checks++;
    if (done_cnt != 90 || o_timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL rand_complete: got %0d transactions err=%b, exp 90 0", done_cnt, o_timeout_err);
    end
    $display("test_random done: %0d transactions", done_cnt);
  endtask

  initial begin
    rst = 1'b1;
    req_d = 3'b000; we_d = 3'b000; err_clr = 1'b0;
    for (int i = 0; i < 3; i++) begin addr_d[i] = 16'h0000; wdata_d[i] = 8'h00; end
    for (int i = 0; i < 65536; i++) begin
      mem[16'(i)] = 8'($urandom);
      ref_mem[16'(i)] = mem[16'(i)];
    end
    test_reset();
    test_cpu_read();
    test_dma_write();
    test_priority();
    test_no_preempt();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
